sprite_pixel_pipe: RTL and testbench
====================================

Name: sprite_pixel_pipe

Overview:
- Sits directly upstream and downstream of the sprite ROM (96x96 sprites, 8-bit palette index per texel, 14-bit address, 1-cycle registered read).
- Takes the VGA beam position and a sprite's screen origin, then generates the ROM read_address.
- Realigns the ROM's returned index with the delayed beam coordinates and flags opaque sprite pixels for the colour mapper.
- Also owns the animation frame counter that selects between a sprite's two animation frames.

Parameters:
- SPR_W, 96, sprite width in pixels
- SPR_H, 96, sprite height in pixels
- ADDR_W, 14, ROM address width
- TRANSP_IDX, 8'h00, palette index treated as transparent
- ANIM_HALF, 16, frameClk rising edges per animation frame; the full cycle is 2*ANIM_HALF

Ports:
- Clk  in  1  pixel/system clock
- Reset_n  in  1  asynchronous active-low reset
- frameClk  in  1  frame strobe (vsync-derived), asynchronous to Clk
- DrawX  in  10  current beam column
- DrawY  in  10  current beam row
- pixel_valid  in  1  beam is in the active region this cycle
- SprX  in  10  sprite top-left column
- SprY  in  10  sprite top-left row
- sprite_en  in  1  sprite is drawn this frame
- read_address  out  ADDR_W  address to the sprite ROM
- rom_data  in  8  ROM data_Out, valid one cycle after read_address is sampled
- anim_sel  out  1  animation frame select to the ROM mux
- pix_hit  out  1  opaque sprite pixel at DrawX_o/DrawY_o
- pix_index  out  8  palette index; 0 when pix_hit=0
- DrawX_o  out  10  DrawX delayed to align with pix_index
- DrawY_o  out  10  DrawY delayed to align with pix_index
- out_valid  out  1  pixel_valid delayed to align with pix_index

Behaviour:
- Reset: asynchronous on Reset_n=0. Every output, pipeline register, synchronizer flop and frame_cnt goes to 0. Reset asserted mid-line discards in-flight pixels. The first valid output follows 3 cycles after the first pixel_valid seen after release.
- Stage 0, combinational on the inputs:
  - dx = DrawX - SprX and dy = DrawY - SprY, computed in 11 bits.
  - in_box = DrawX >= SprX && DrawX < SprX + SPR_W && DrawY >= SprY && DrawY < SprY + SPR_H.
  - All comparisons are 11-bit, so SprX + SPR_W > 1023 does not wrap and DrawX < SprX never hits.
  - hit0 = in_box && sprite_en && pixel_valid.
- Edge 1:
  - If hit0, read_address <= dy*SPR_W + dx. This is a constant multiply; for 96 it is (dy<<6)+(dy<<5). Range is 0..SPR_W*SPR_H-1, i.e. 9215 max.
  - If !hit0, read_address holds its previous value.
  - hit1 <= hit0. DrawX/DrawY/pixel_valid advance one stage.
- Edge 2: the ROM samples read_address, and rom_data becomes valid. hit2, coordinates and valid advance one stage.
- Edge 3 (outputs):
  - pix_hit <= hit2 && rom_data != TRANSP_IDX.
  - pix_index <= pix_hit-condition ? rom_data : 0.
  - DrawX_o/DrawY_o/out_valid <= stage-2 values.
- Latency: fixed 3 cycles from inputs to outputs. Fully pipelined at one pixel per cycle with no stalls and no backpressure.
- Animation:
  - frameClk passes through a 2-flop synchronizer; a rising edge is detected on the synchronized value.
  - frame_cnt counts 0..2*ANIM_HALF-1 and wraps to 0, incrementing once per rising edge. A held-high frameClk does not advance it.
  - anim_sel is registered: 0 while frame_cnt < ANIM_HALF, otherwise 1.
  - Latency from a frameClk rise to the frame_cnt change is 3 Clk cycles.
- Simultaneous events:
  - A frameClk edge coinciding with pixel activity has no effect on the pixel pipeline.
  - anim_sel may change mid-frame only if frameClk is not vsync-aligned; the block does not guard against this.
- Changing SprX/SprY/sprite_en mid-line takes effect for the pixel presented that same cycle. There is no shadowing.

Test Plan:
- Reset: hold Reset_n=0 with random inputs -> all outputs 0. Pulse Reset_n low mid-line with hits in flight -> outputs 0 immediately (asynchronous), no stale pix_hit after release.
- Addressing: SprX=100, SprY=50. (100,50) -> read_address=0 at N+1. (195,50) -> 95. (100,51) -> 96. (195,145) -> 9215. (196,145) and (99,50) -> no hit, read_address holds 9215.
- Latency/transparency: ROM model returning addr[7:0] one cycle after sampling. (101,50) -> at N+3 pix_hit=1, pix_index=8'h01, DrawX_o=101, DrawY_o=50, out_valid=1. (100,50) returns 8'h00 -> pix_hit=0, pix_index=0.
- Screen-edge clipping: SprX=1000, SprY=0, DrawX=1023, DrawY=0 -> hit, read_address=23. DrawX=0 -> no hit. sprite_en=0 or pixel_valid=0 at an in-box position -> pix_hit=0 at N+3.
- Animation: 15 frameClk rises -> anim_sel=0. 16th rise -> anim_sel=1. 32nd rise -> anim_sel=0. frameClk held high for 100 cycles -> exactly one count.
- Back-to-back streaming: 96 consecutive in-box pixels on one row -> read_address increments by 1 every cycle, and pix_index matches the ROM model every cycle with a constant 3-cycle lag.

Source files
------------

// File: rtl/sprite_pixel_pipe.sv
// Sprite ROM front/back end: turns beam position into a ROM address, realigns the
// returned palette index with the delayed beam, and runs the two-frame animation counter.
`timescale 1ns/1ps

module sprite_pixel_pipe #(
  parameter int         SPR_W      = 96,
  parameter int         SPR_H      = 96,
  parameter int         ADDR_W     = 14,
  parameter logic [7:0] TRANSP_IDX = 8'h00,
  parameter int         ANIM_HALF  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frameClk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pixel_valid,
  input  logic [9:0]        SprX,
  input  logic [9:0]        SprY,
  input  logic              sprite_en,
  output logic [ADDR_W-1:0] read_address,
  input  logic [7:0]        rom_data,
  output logic              anim_sel,
  output logic              pix_hit,
  output logic [7:0]        pix_index,
  output logic [9:0]        DrawX_o,
  output logic [9:0]        DrawY_o,
  output logic              out_valid
);

  localparam int CNT_W = $clog2(2 * ANIM_HALF);

  // Stage 0: all box arithmetic is done in 11 bits so a sprite hanging off the
  // right or bottom screen edge clips instead of wrapping back to column/row 0.
  logic [10:0]       draw_x, draw_y, spr_x, spr_y;
  logic [10:0]       dx, dy;
  logic              in_box, hit0;
  logic [ADDR_W-1:0] addr_next;

  assign draw_x = {1'b0, DrawX};
  assign draw_y = {1'b0, DrawY};
  assign spr_x  = {1'b0, SprX};
  assign spr_y  = {1'b0, SprY};
  assign dx     = draw_x - spr_x;
  assign dy     = draw_y - spr_y;

  assign in_box = (draw_x >= spr_x) && (draw_x < spr_x + 11'(SPR_W)) &&
                  (draw_y >= spr_y) && (draw_y < spr_y + 11'(SPR_H));
  assign hit0   = in_box && sprite_en && pixel_valid;

  assign addr_next = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);

  // Stages 1 and 2 carry hit and beam coordinates alongside the ROM access.
  logic       hit1, hit2;
  logic [9:0] x1, y1, x2, y2;
  logic       v1, v2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      hit1         <= 1'b0;
      x1           <= '0;
      y1           <= '0;
      v1           <= 1'b0;
      hit2         <= 1'b0;
      x2           <= '0;
      y2           <= '0;
      v2           <= 1'b0;
      pix_hit      <= 1'b0;
      pix_index    <= '0;
      DrawX_o      <= '0;
      DrawY_o      <= '0;
      out_valid    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage capture the previous
      // stage's pre-edge value, which is what keeps the pipeline one pixel per stage.
      if (hit0) read_address <= addr_next;
      hit1      <= hit0;
      x1        <= DrawX;
      y1        <= DrawY;
      v1        <= pixel_valid;
      hit2      <= hit1;
      x2        <= x1;
      y2        <= y1;
      v2        <= v1;
      pix_hit   <= hit2 && (rom_data != TRANSP_IDX);
      pix_index <= (hit2 && (rom_data != TRANSP_IDX)) ? rom_data : 8'h00;
      DrawX_o   <= x2;
      DrawY_o   <= y2;
      out_valid <= v2;
    end
  end

  // Animation: frameClk is asynchronous, so it is brought in through two flops and
  // the rising edge is taken from a third flop holding the previous synced value.
  logic             frame_s1, frame_s2, frame_prev;
  logic             frame_rise;
  logic [CNT_W-1:0] frame_cnt;

  assign frame_rise = frame_s2 && !frame_prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_s1   <= 1'b0;
      frame_s2   <= 1'b0;
      frame_prev <= 1'b0;
      frame_cnt  <= '0;
      anim_sel   <= 1'b0;
    end else begin
      frame_s1   <= frameClk;
      frame_s2   <= frame_s1;
      frame_prev <= frame_s2;
      if (frame_rise) begin
        if (frame_cnt == CNT_W'(2 * ANIM_HALF - 1)) frame_cnt <= '0;
        else                                        frame_cnt <= frame_cnt + 1'b1;
      end
      anim_sel <= (frame_cnt >= CNT_W'(ANIM_HALF));
    end
  end

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Scoreboard bench for sprite_pixel_pipe: directed pixels push expected outputs,
// a negedge monitor pops and compares them with a fixed 3-cycle lag.
`timescale 1ns/1ps

module tb_sprite_pixel_pipe;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        frameClk = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, SprX = '0, SprY = '0;
  logic        pixel_valid = 1'b0, sprite_en = 1'b0;
  logic [13:0] read_address;
  logic [7:0]  rom_data = '0;
  logic        anim_sel, pix_hit, out_valid;
  logic [7:0]  pix_index;
  logic [9:0]  DrawX_o, DrawY_o;

  sprite_pixel_pipe dut (
    .Clk(Clk), .Reset_n(Reset_n), .frameClk(frameClk),
    .DrawX(DrawX), .DrawY(DrawY), .pixel_valid(pixel_valid),
    .SprX(SprX), .SprY(SprY), .sprite_en(sprite_en),
    .read_address(read_address), .rom_data(rom_data), .anim_sel(anim_sel),
    .pix_hit(pix_hit), .pix_index(pix_index),
    .DrawX_o(DrawX_o), .DrawY_o(DrawY_o), .out_valid(out_valid)
  );

  always #5 Clk = ~Clk;

  // ROM stand-in: contents are the low address byte, one-cycle registered read.
  always @(posedge Clk) rom_data <= read_address[7:0];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       hit;
    logic [7:0] idx;
    int         due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Reset_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_latency", cyc, e.due);
          check("pix_hit", pix_hit, e.hit);
          check("pix_index", pix_index, e.idx);
          check("DrawX_o", DrawX_o, e.x);
          check("DrawY_o", DrawY_o, e.y);
        end
      end else begin
        if (pix_hit || pix_index != 8'h00) check("hit_without_valid", {pix_hit, pix_index}, 0);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          check("missing_output", 0, 1);
        end
      end
    end
  end

  // Called on a negedge; returns on the next negedge, when edge-1 results are visible.
  task automatic pix(input int x, input int y, input logic pv, input logic en,
                     input logic [7:0] idx);
    exp_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    pixel_valid = pv;
    sprite_en = en;
    if (pv) begin
      e.x = 10'(x);
      e.y = 10'(y);
      e.hit = (idx != 8'h00);
      e.idx = idx;
      e.due = cyc + 3;
      sb.push_back(e);
    end
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    pixel_valid = 1'b0;
    sprite_en = 1'b0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic drain();
    int n = 0;
    pixel_valid = 1'b0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic frame_rise(input int hold_ns);
    #3 frameClk = 1'b1;
    #(hold_ns) frameClk = 1'b0;
    #47;
  endtask

  initial begin
    #1 Reset_n = 1'b0;

    // Reset held with random inputs.
    repeat (5) begin
      @(negedge Clk);
      DrawX = 10'($urandom); DrawY = 10'($urandom);
      SprX = 10'($urandom);  SprY = 10'($urandom);
      pixel_valid = 1'($urandom); sprite_en = 1'($urandom);
      #1;
      check("reset_outputs", {read_address, anim_sel, pix_hit, pix_index,
                              DrawX_o, DrawY_o, out_valid}, 0);
    end
    @(negedge Clk);
    pixel_valid = 1'b0;
    sprite_en = 1'b0;
    Reset_n = 1'b1;
    @(negedge Clk);

    // Addressing with sprite at (100,50).
    SprX = 10'd100; SprY = 10'd50;
    pix(100, 50, 1, 1, 8'h00);  check("addr_100_50", read_address, 0);
    pix(195, 50, 1, 1, 8'h5F);  check("addr_195_50", read_address, 95);
    pix(100, 51, 1, 1, 8'h60);  check("addr_100_51", read_address, 96);
    pix(195, 145, 1, 1, 8'hFF); check("addr_195_145", read_address, 9215);
    pix(196, 145, 1, 1, 8'h00); check("addr_hold_196_145", read_address, 9215);
    pix(99, 50, 1, 1, 8'h00);   check("addr_hold_99_50", read_address, 9215);

    // Latency and transparency.
    pix(101, 50, 1, 1, 8'h01);  check("addr_101_50", read_address, 1);
    pix(100, 50, 1, 1, 8'h00);  check("addr_transp", read_address, 0);
    drain();

    // Screen-edge clipping with sprite at (1000,0).
    SprX = 10'd1000; SprY = 10'd0;
    pix(1023, 0, 1, 1, 8'h17);  check("addr_edge_1023", read_address, 23);
    pix(0, 0, 1, 1, 8'h00);     check("addr_nowrap_0", read_address, 23);
    pix(1010, 5, 1, 0, 8'h00);  check("addr_sprite_off", read_address, 23);
    pix(1010, 5, 0, 1, 8'h00);  check("addr_invalid_pix", read_address, 23);
    drain();

    // Reset pulsed mid-line with hits in flight.
    SprX = 10'd100; SprY = 10'd50;
    DrawX = 10'd101; DrawY = 10'd50; pixel_valid = 1'b1; sprite_en = 1'b1;
    @(negedge Clk);
    DrawX = 10'd102;
    @(negedge Clk);
    pixel_valid = 1'b0;
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("midline_reset_outputs", {read_address, pix_hit, pix_index,
                                    DrawX_o, DrawY_o, out_valid}, 0);
    sb.delete();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    idle(4);
    check("no_stale_hit", {pix_hit, pix_index, out_valid}, 0);
    idle(2);

    // 96 back-to-back pixels across row 50: address i, ROM returns i.
    for (int i = 0; i < 96; i++) begin
      pix(100 + i, 50, 1, 1, 8'(i));
      check("stream_addr", read_address, i);
    end
    drain();

    // Animation counter.
    idle(2);
    repeat (15) frame_rise(33);
    repeat (6) @(negedge Clk);
    check("anim_after_15", anim_sel, 0);
    frame_rise(1000);
    repeat (6) @(negedge Clk);
    check("anim_after_16_held", anim_sel, 1);
    repeat (15) frame_rise(33);
    repeat (6) @(negedge Clk);
    check("anim_after_31", anim_sel, 1);
    frame_rise(33);
    repeat (6) @(negedge Clk);
    check("anim_after_32", anim_sel, 0);

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
